ramp_follower: RTL and testbench

Multi-channel, rate-controlled successor to `follower`. Each channel's registered output value slews toward its own target input in bounded steps, without overshoot. Steps are paced by a shared programmable prescaler. Used wherever a control value (PWM duty, DAC code, setpoint) must approach a new command gradually instead of jumping.

---
 rtl/ramp_follower.sv | 75 +++++++
 tb/tb_ramp_follower.sv | 218 +++++++++++++++++++++
 2 files changed

// File: rtl/ramp_follower.sv
// Multi-channel slew limiter: each channel value steps toward its target by at most `step`
// per prescaler tick, clamped so it never overshoots or wraps.
module ramp_follower #(
    parameter int unsigned bitwidth       = 8,
    parameter int unsigned channels       = 4,
    parameter int unsigned initial_value  = 0,
    parameter int unsigned prescaler_bits = 8
) (
    input  logic                         clock,
    input  logic                         reset,
    input  logic                         enable,
    input  logic [prescaler_bits-1:0]    prescaler,
    input  logic [bitwidth-1:0]          step,
    input  logic [channels-1:0]          load,
    input  logic [channels*bitwidth-1:0] target_value,
    output logic [channels*bitwidth-1:0] value,
    output logic [channels-1:0]          at_target,
    output logic                         tick
);

    logic [prescaler_bits-1:0] count;
    logic                      strobe;

    // >= rather than == so that lowering the period mid-count fires promptly instead of wrapping
    assign strobe = enable && (count >= prescaler);

    always_ff @(posedge clock or posedge reset) begin
        if (reset) begin
            count <= '0;
            tick  <= 1'b0;
        end else begin
            tick <= strobe;
            if (strobe || !enable) begin
                count <= '0;
            end else begin
                count <= count + 1'b1;
            end
        end
    end

    for (genvar i = 0; i < channels; i++) begin : g_ch
        logic [bitwidth-1:0] cur;
        logic [bitwidth-1:0] tgt;
        logic [bitwidth-1:0] up_diff;
        logic [bitwidth-1:0] dn_diff;
        logic [bitwidth-1:0] nxt;

        assign tgt     = target_value[i*bitwidth +: bitwidth];
        assign up_diff = tgt - cur;
        assign dn_diff = cur - tgt;

        always_comb begin
            nxt = cur;
            if (load[i]) begin
                nxt = tgt;
            end else if (strobe && (cur < tgt)) begin
                nxt = cur + ((step < up_diff) ? step : up_diff);
            end else if (strobe && (cur > tgt)) begin
                nxt = cur - ((step < dn_diff) ? step : dn_diff);
            end
        end

        always_ff @(posedge clock or posedge reset) begin
            if (reset) begin
                cur <= bitwidth'(initial_value);
            end else begin
                cur <= nxt;
            end
        end

        assign value[i*bitwidth +: bitwidth] = cur;
        assign at_target[i]                  = (cur == tgt);
    end

endmodule

// File: tb/tb_ramp_follower.sv
// Randomized and directed bench for ramp_follower, checked against an integer reference model.
module tb_ramp_follower;

    localparam int BW = 8;
    localparam int CH = 2;
    localparam int PB = 8;

    logic              clock = 1'b0;
    logic              reset;
    logic              enable;
    logic [PB-1:0]     prescaler;
    logic [BW-1:0]     step;
    logic [CH-1:0]     load;
    logic [CH*BW-1:0]  target_value;
    logic [CH*BW-1:0]  value;
    logic [CH-1:0]     at_target;
    logic              tick;

    int tests = 0;
    int fails = 0;

    // Reference state
    int m_val[CH];
    int m_cnt;
    int m_tick;

    ramp_follower #(
        .bitwidth      (BW),
        .channels      (CH),
        .initial_value (0),
        .prescaler_bits(PB)
    ) dut (
        .clock       (clock),
        .reset       (reset),
        .enable      (enable),
        .prescaler   (prescaler),
        .step        (step),
        .load        (load),
        .target_value(target_value),
        .value       (value),
        .at_target   (at_target),
        .tick        (tick)
    );

    always #5 clock = ~clock;

    task automatic check_eq(input string tag, input int got, input int exp);
        tests++;
        if (got != exp) begin
            fails++;
            $display("FAIL %s: got %0d, expected %0d at %0t", tag, got, exp, $time);
        end
    endtask

    function automatic int tgt(input int i);
        return int'(target_value[i*BW +: BW]);
    endfunction

    function automatic int min2(input int a, input int b);
        return (a < b) ? a : b;
    endfunction

    task automatic model_reset();
        for (int i = 0; i < CH; i++) m_val[i] = 0;
        m_cnt  = 0;
        m_tick = 0;
    endtask

    task automatic check_outputs();
        for (int i = 0; i < CH; i++) begin
            check_eq($sformatf("value%0d", i), int'(value[i*BW +: BW]), m_val[i]);
            check_eq($sformatf("at_target%0d", i), int'(at_target[i]), int'(m_val[i] == tgt(i)));
        end
        check_eq("tick", int'(tick), m_tick);
    endtask

    // One clock edge: predict from the inputs present before the edge, then compare just after it
    task automatic cycle();
        int s;
        int nv[CH];
        s = int'(enable && (m_cnt >= int'(prescaler)));
        for (int i = 0; i < CH; i++) begin
            int t;
            t = tgt(i);
            if (load[i]) nv[i] = t;
            else if (s != 0 && m_val[i] < t) nv[i] = m_val[i] + min2(int'(step), t - m_val[i]);
            else if (s != 0 && m_val[i] > t) nv[i] = m_val[i] - min2(int'(step), m_val[i] - t);
            else nv[i] = m_val[i];
        end
        @(posedge clock);
        #1;
        m_cnt  = (s != 0 || !enable) ? 0 : m_cnt + 1;
        m_tick = s;
        for (int i = 0; i < CH; i++) m_val[i] = nv[i];
        check_outputs();
    endtask

    task automatic cycles(input int n);
        for (int k = 0; k < n; k++) cycle();
    endtask

    task automatic snap0(input int v);
        target_value[7:0] = 8'(v);
        load = 2'b01;
        cycle();
        load = 2'b00;
    endtask

    initial begin
        reset        = 1'b1;
        enable       = 1'b0;
        prescaler    = '0;
        step         = '0;
        load         = '0;
        target_value = '0;
        model_reset();
        #12;
        reset = 1'b0;
        #1;
        check_outputs();

        // Unit slew
        step = 8'd1;
        target_value[7:0] = 8'd5;
        enable = 1'b1;
        cycles(5);
        check_eq("slew_edge5", int'(value[7:0]), 5);
        check_eq("slew_at_target", int'(at_target[0]), 1);
        cycles(2);
        check_eq("slew_hold", int'(value[7:0]), 5);

        // Clamped steps up then down
        snap0(0);
        step = 8'd4;
        target_value[7:0] = 8'd10;
        cycles(3);
        check_eq("clamp_up", int'(value[7:0]), 10);
        step = 8'd3;
        target_value[7:0] = 8'd2;
        cycles(3);
        check_eq("clamp_down", int'(value[7:0]), 2);

        // Prescaler pacing with an enable gap
        snap0(0);
        enable = 1'b0;
        cycle();
        enable    = 1'b1;
        prescaler = 8'd3;
        step      = 8'd1;
        target_value[7:0] = 8'd3;
        cycles(5);
        enable = 1'b0;
        cycles(6);
        check_eq("pace_frozen_tick", int'(tick), 0);
        enable = 1'b1;
        cycles(10);
        check_eq("pace_done", int'(value[7:0]), 3);

        // Load on channel 1 while channel 0 ramps
        prescaler = 8'd0;
        target_value = {8'd77, 8'd200};
        cycles(3);
        load = 2'b10;
        cycle();
        load = 2'b00;
        check_eq("load1", int'(value[15:8]), 77);
        cycles(3);

        // Range extremes
        snap0(250);
        step = 8'd200;
        target_value[7:0] = 8'd255;
        cycle();
        check_eq("extreme_top", int'(value[7:0]), 255);
        snap0(3);
        step = 8'd255;
        target_value[7:0] = 8'd0;
        cycle();
        check_eq("extreme_bottom", int'(value[7:0]), 0);

        // Asynchronous reset mid-ramp
        prescaler = 8'd2;
        step = 8'd1;
        target_value[7:0] = 8'd50;
        cycles(7);
        #2;
        reset = 1'b1;
        #1;
        model_reset();
        check_outputs();
        #2;
        reset = 1'b0;
        cycles(2);
        check_eq("rst_edge2", int'(value[7:0]), 0);
        cycle();
        check_eq("rst_edge3", int'(value[7:0]), 1);
        check_eq("rst_tick3", int'(tick), 1);

        // Random traffic
        for (int n = 0; n < 400; n++) begin
            enable = ($urandom_range(0, 7) != 0);
            if ($urandom_range(0, 15) == 0) prescaler = 8'($urandom_range(0, 4));
            if ($urandom_range(0, 7) == 0)
                step = ($urandom_range(0, 3) == 0) ? 8'($urandom) : 8'($urandom_range(0, 9));
            if ($urandom_range(0, 9) == 0) target_value[7:0] = 8'($urandom);
            if ($urandom_range(0, 9) == 0) target_value[15:8] = 8'($urandom);
            load = ($urandom_range(0, 19) == 0) ? 2'($urandom) : 2'b00;
            #1;
            for (int i = 0; i < CH; i++)
                check_eq("rand_at_target", int'(at_target[i]), int'(m_val[i] == tgt(i)));
            cycle();
        end

        $display("[TB] %0d tests run, %0d failed", tests, fails);
        $finish;
    end

endmodule
